// File: rtl/rdm_pkg.sv
// ---------------------------------------------------------------------------
// rdm_pkg -- shared definitions for the read_master DMA read engine.
//   CSR word addresses, CTRL/SRST/STATUS bit positions and the controller
//   state enumeration. Imported by read_master and its testbench.
// ---------------------------------------------------------------------------
package rdm_pkg;

   // CSR map (3-bit word address)
   localparam logic [2:0] CSR_BASE   = 3'd0;
   localparam logic [2:0] CSR_LENGTH = 3'd1;
   localparam logic [2:0] CSR_STEP   = 3'd2;
   localparam logic [2:0] CSR_CTRL   = 3'd3;
   localparam logic [2:0] CSR_STATUS = 3'd4;
   localparam logic [2:0] CSR_SRST   = 3'd5;

   // CTRL / SRST bits
   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_LOOP_BIT  = 1;
   localparam int SRST_BIT       = 0;

   // STATUS bits
   localparam int STAT_BUSY_BIT = 0;
   localparam int STAT_DONE_BIT = 1;
   localparam int STAT_LOOP_BIT = 2;
   localparam int STAT_FILL_LSB = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_DRAIN = 3'd2,
      ST_DONE  = 3'd3,
      ST_FLUSH = 3'd4
   } state_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo -- single-clock show-ahead FIFO with occupancy count.
//   clk, rst     : clock, asynchronous active-low reset
//   i_flush      : empty the FIFO (wins over push/pop)
//   i_push/i_data: write port, ignored when full
//   i_pop        : drop the head entry, ignored when empty
//   o_data       : head entry (valid while !o_empty)
//   o_empty      : no entries held
//   o_count      : entries held, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic [W-1:0]             i_data,
   input  logic                     i_pop,
   output logic [W-1:0]             o_data,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign w_push = i_push && (r_count != FULL_CNT);
   assign w_pop  = i_pop  && (r_count != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         // Simultaneous push and pop leave the count unchanged.
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage has no reset; the pointers and count define what is valid,
   // and a reset-free array maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/read_master.sv
// ---------------------------------------------------------------------------
// read_master -- CSR-programmed DDR read engine feeding a ready/valid stream.
//   Reads LENGTH words from BASE, BASE+STEP, ... (optionally looping) and
//   streams them out in request order through an internal FIFO. Requests
//   are throttled so returning data always has room in the FIFO.
//   clk, rst                   : clock, asynchronous active-low reset
//   ddr_addr/read/waitrequest  : DDR read request (Avalon-style)
//   ddr_readdata/readdatavalid : DDR read response, in request order
//   addr/writedata/write/read  : CSR slave, readdata one cycle after read
//   d_out/d_out_valid/ready    : output stream
// ---------------------------------------------------------------------------
module read_master
   import rdm_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] ddr_addr,
   output logic              ddr_read,
   input  logic              ddr_waitrequest,
   input  logic [DATA_W-1:0] ddr_readdata,
   input  logic              ddr_readdatavalid,
   input  logic [2:0]        addr,
   input  logic [15:0]       writedata,
   input  logic              write,
   input  logic              read,
   output logic [15:0]       readdata,
   output logic [DATA_W-1:0] d_out,
   output logic              d_out_valid,
   input  logic              d_out_ready
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] DEPTH_SUM = (CW+1)'(FIFO_DEPTH);

   state_t            r_state, w_next_state;
   logic [15:0]       r_base, r_length, r_step, r_readdata;
   logic [1:0]        r_ctrl;
   logic              r_srst, r_loop, r_done;
   logic [ADDR_W-1:0] r_run_base, r_run_step, r_addr;
   logic [15:0]       r_run_len, r_idx;
   logic [CW-1:0]     r_inflight;
   logic [CW-1:0]     w_fifo_count;
   logic [DATA_W-1:0] w_fifo_data;
   logic              w_fifo_empty, w_flush, w_busy, w_read;
   logic              w_ctrl_wr, w_start, w_srst, w_loop_clr, w_loop_eff;
   logic              w_accept, w_last, w_room;
   logic [15:0]       w_status;

   assign w_ctrl_wr  = write && (addr == CSR_CTRL);
   // Start fires on a 0->1 edge of CTRL.start, and only from IDLE or DONE.
   assign w_start    = w_ctrl_wr && writedata[CTRL_START_BIT] && !r_ctrl[CTRL_START_BIT]
                       && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_srst     = write && (addr == CSR_SRST) && writedata[SRST_BIT];
   assign w_loop_clr = w_ctrl_wr && !writedata[CTRL_LOOP_BIT];
   // A loop clear arriving with the last request of a pass ends that pass.
   assign w_loop_eff = r_loop && !w_loop_clr;
   assign w_accept   = w_read && !ddr_waitrequest;
   assign w_last     = (r_idx == r_run_len - 16'd1);
   // In-flight plus buffered never exceeds the FIFO depth, so a returning
   // word always finds a free slot.
   assign w_room     = ({1'b0, r_inflight} + {1'b0, w_fifo_count}) < DEPTH_SUM;
   assign w_flush    = w_srst || (r_state == ST_FLUSH);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block order.
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_next_state;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      // NOTE: default first so no path leaves w_next_state unassigned (latch).
      w_next_state = r_state;
      if (w_srst) begin
         w_next_state = ST_FLUSH;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE:
               if (w_start) w_next_state = (r_length == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE:
               if (w_accept && w_last && !w_loop_eff) w_next_state = ST_DRAIN;
            ST_DRAIN:
               if ((r_inflight == '0) && w_fifo_empty) w_next_state = ST_DONE;
            ST_FLUSH:
               if (r_inflight == '0) w_next_state = ST_IDLE;
            default:
               w_next_state = ST_IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_read = 1'b0;
      w_busy = 1'b0;
      case (r_state)
         ST_ISSUE: begin w_read = w_room; w_busy = 1'b1; end
         ST_DRAIN, ST_FLUSH: w_busy = 1'b1;
         default: ;
      endcase
   end

   // ---------------- CSR registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_base   <= '0;
         r_length <= '0;
         r_step   <= '0;
         r_ctrl   <= '0;
         r_srst   <= 1'b0;
      end else if (write) begin
         case (addr)
            CSR_BASE:   r_base   <= writedata;
            CSR_LENGTH: r_length <= writedata;
            CSR_STEP:   r_step   <= writedata;
            CSR_CTRL:   r_ctrl   <= writedata[1:0];
            CSR_SRST:   r_srst   <= writedata[SRST_BIT];
            default: ;
         endcase
      end
   end

   always_comb begin
      w_status                          = '0;
      w_status[STAT_BUSY_BIT]           = w_busy;
      w_status[STAT_DONE_BIT]           = r_done;
      w_status[STAT_LOOP_BIT]           = r_loop;
      w_status[STAT_FILL_LSB +: 8]      = 8'(w_fifo_count);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_readdata <= '0;
      end else if (read) begin
         case (addr)
            CSR_BASE:   r_readdata <= r_base;
            CSR_LENGTH: r_readdata <= r_length;
            CSR_STEP:   r_readdata <= r_step;
            CSR_CTRL:   r_readdata <= {14'd0, r_ctrl};
            CSR_STATUS: r_readdata <= w_status;
            CSR_SRST:   r_readdata <= {15'd0, r_srst};
            default:    r_readdata <= '0;
         endcase
      end
   end

   // ---------------- run context, address walk, counters ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_run_base <= '0;
         r_run_step <= '0;
         r_run_len  <= '0;
         r_idx      <= '0;
         r_addr     <= '0;
         r_loop     <= 1'b0;
      end else if (w_start) begin
         // Programming is snapshotted here; later CSR writes wait for the next run.
         r_run_base <= ADDR_W'(r_base);
         r_run_step <= ADDR_W'(r_step);
         r_run_len  <= r_length;
         r_idx      <= '0;
         r_addr     <= ADDR_W'(r_base);
         r_loop     <= writedata[CTRL_LOOP_BIT];
      end else begin
         if (w_srst || w_loop_clr) r_loop <= 1'b0;
         // Running sum instead of BASE + idx*STEP; wraps modulo 2^ADDR_W.
         if ((r_state == ST_ISSUE) && w_accept) begin
            if (w_last) begin
               r_idx  <= '0;
               r_addr <= r_run_base;
            end else begin
               r_idx  <= r_idx + 16'd1;
               r_addr <= r_addr + r_run_step;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_done     <= 1'b0;
         r_inflight <= '0;
      end else begin
         if (w_srst)
            r_done <= 1'b0;
         else if ((w_next_state == ST_DONE) && ((r_state != ST_DONE) || w_start))
            r_done <= 1'b1;
         else if (w_start)
            r_done <= 1'b0;

         case ({w_accept, ddr_readdatavalid})
            2'b10:   r_inflight <= r_inflight + 1'b1;
            2'b01:   r_inflight <= (r_inflight != '0) ? r_inflight - 1'b1 : r_inflight;
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   // ---------------- output buffer ----------------
   sync_fifo #(
      .W     (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (w_flush),
      .i_push  (ddr_readdatavalid && !w_flush),
      .i_data  (ddr_readdata),
      .i_pop   (d_out_valid && d_out_ready),
      .o_data  (w_fifo_data),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   assign ddr_read    = w_read;
   assign ddr_addr    = r_addr;
   assign readdata    = r_readdata;
   assign d_out_valid = !w_fifo_empty;
   assign d_out       = w_fifo_empty ? '0 : w_fifo_data;

endmodule

// File: doc/read_master.md
READ_MASTER -- requirements
Module: read_master

Interface
REQ-001 SHALL have parameter DATA_W, default 16: stream and DDR data width.
REQ-002 SHALL have parameter ADDR_W, default 32: DDR word-address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, power of two: output buffer depth and the maximum reads in flight.
REQ-004 SHALL have port clk, input, 1: the only clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have DDR ports: ddr_addr (output, ADDR_W), ddr_read (output, 1), ddr_waitrequest (input, 1), ddr_readdata (input, DATA_W), ddr_readdatavalid (input, 1).
REQ-007 SHALL have CSR slave ports: addr (input, 3), writedata (input, 16), write (input, 1), read (input, 1), readdata (output, 16).
REQ-008 SHALL have stream-out ports: d_out (output, DATA_W), d_out_valid (output, 1), d_out_ready (input, 1).

Function
REQ-009 SHALL decode the CSR map as: 0 BASE, 1 LENGTH (word count), 2 STEP, 3 CTRL (bit0 start, bit1 loop), 4 STATUS (read-only), 5 SRST (bit0 soft reset). All registers other than STATUS are read/write.
REQ-010 SHALL return readdata one cycle after a read strobe; unmapped addresses 6 and 7 SHALL read 0.
REQ-011 SHALL define STATUS as: bit0 busy, bit1 done (sticky, cleared by start), bit2 loop active, bits15:8 current FIFO fill level.
REQ-012 SHALL start only on a 0->1 transition of CTRL.bit0 while in IDLE or DONE; a start in any other state SHALL be ignored.
REQ-013 SHALL latch BASE, LENGTH, STEP and loop at start; CSR writes made while busy SHALL affect only the next run.
REQ-014 SHALL use states IDLE, ISSUE, DRAIN, DONE, FLUSH.
REQ-015 IDLE->ISSUE on start with LENGTH!=0; IDLE->DONE on start with LENGTH==0.
REQ-016 In ISSUE: ddr_addr = zero-extended BASE + idx*zero-extended STEP, computed modulo 2^ADDR_W; idx runs from 0 to LENGTH-1.
REQ-017 SHALL hold ddr_read and ddr_addr stable while ddr_waitrequest=1; a request is accepted on a cycle where ddr_read=1 and ddr_waitrequest=0.
REQ-018 SHALL assert ddr_read only while (in-flight reads + FIFO count) < FIFO_DEPTH, so readdatavalid data never meets a full FIFO.
REQ-019 ISSUE->DRAIN after the LENGTH-th request is accepted; with loop=1, SHALL instead reset idx to 0 and remain in ISSUE.
REQ-020 DRAIN->DONE once in-flight reads are 0 and the FIFO is empty; DONE sets STATUS.done.
REQ-021 SHALL push ddr_readdata into the FIFO on every ddr_readdatavalid, in request order.
REQ-022 d_out_valid SHALL equal FIFO non-empty, with d_out at the FIFO head; a pop occurs when d_out_valid && d_out_ready; a push and a pop in the same cycle SHALL leave the count unchanged.
REQ-023 A write of CTRL.bit1=0 while loop is active SHALL end the run at the end of the current pass (ISSUE->DRAIN after idx LENGTH-1).
REQ-024 A write of SRST.bit0=1 from any state SHALL enter FLUSH: drop ddr_read, empty the FIFO, and discard returning data until in-flight reads reach 0, then go to IDLE with done=0.
REQ-025 The in-flight counter SHALL increment on an accepted request and decrement on readdatavalid; when both occur in one cycle it SHALL be unchanged.

Reset
REQ-026 On rst=0: state IDLE, ddr_read=0, ddr_addr=0, d_out_valid=0, d_out=0, readdata=0, all CSRs 0, FIFO empty, counters 0.
REQ-027 Reset release SHALL take effect on the first rising clk edge after rst returns high; no read SHALL be issued before a start.

Structure
REQ-028 The CSR address constants, the STATUS bit positions and the state enumeration SHALL live in the shared package rdm_pkg.
REQ-029 The FIFO SHALL be a separate sub-module, sync_fifo: single clock, show-ahead, with a count output.

Verification
REQ-030 BASE=0x10, LENGTH=4, STEP=2, start, waitrequest=0, ready=1 -> ddr_addr 0x10, 0x12, 0x14, 0x16; d_out equals the returned data in order; done=1.
REQ-031 Waitrequest held for 3 cycles on the second request -> ddr_addr stays 0x12 for those 3 cycles; no request is duplicated or dropped.
REQ-032 d_out_ready=0 with LENGTH=40 -> exactly FIFO_DEPTH (16) requests are accepted and then ddr_read deasserts; after ready=1, all 40 words arrive with none lost.
REQ-033 LENGTH=0, start -> DONE on the next cycle, no ddr_read, done=1.
REQ-034 Loop=1 with LENGTH=3 -> addresses repeat base, +step, +2step; clearing loop finishes the current pass and then reaches DONE.
REQ-035 SRST with 5 reads in flight -> FIFO empties, the 5 returning words are discarded, state returns to IDLE, d_out_valid=0.
